// File: rtl/t3_pkg.sv
// Shared definitions for the T3 byte queue front end.
package t3_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      COLLECT  = 1'b0,
      WAIT_ACK = 1'b1
   } coll_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings the asynchronous bit strobe and its data bit into the clock domain
// and flags the first synchronized cycle of each strobe.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock_1MHz,
   input  logic rst,
   input  logic write_in,
   input  logic data_in,
   output logic bit_sync,
   output logic write_rise
);

   logic [SYNC_STAGES-1:0] wr_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   wr_prev_q;

   // Synchronizer chains plus one history flop on the strobe for edge detect.
   always_ff @(posedge clock_1MHz) begin
      if (!rst) begin
         wr_sync_q  <= '0;
         dat_sync_q <= '0;
         wr_prev_q  <= 1'b0;
      end else begin
         wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], write_in};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data_in};
         wr_prev_q  <= wr_sync_q[SYNC_STAGES-1];
      end
   end

   // data_in is stable while the strobe is high, so the synced bit is valid
   // in the edge cycle.
   assign bit_sync   = dat_sync_q[SYNC_STAGES-1];
   assign write_rise = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;

endmodule

// File: rtl/serial_byte_collector.sv
// Collects MSB-first serial bits into a word and holds it for the byte queue
// until it is acknowledged.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   COLLECT  | shifting in bits on each strobe edge (unless queue_full)
//   WAIT_ACK | word presented on data_out with enq_out high; bits dropped
module serial_byte_collector
   import t3_pkg::*;
#(
   parameter int WIDTH       = BYTE_W,
   parameter int SYNC_STAGES = 2,
   localparam int CW         = $clog2(WIDTH + 1)
) (
   input  logic             clock_1MHz,
   input  logic             rst,
   input  logic             data_in,
   input  logic             write_in,
   input  logic             queue_full,
   input  logic             enq_ack,
   output logic             status_out,
   output logic             enq_out,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    bit_count
);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   coll_state_t      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             enq_q, enq_d;
   logic             bit_sync;
   logic             write_rise;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock_1MHz (clock_1MHz),
      .rst        (rst),
      .write_in   (write_in),
      .data_in    (data_in),
      .bit_sync   (bit_sync),
      .write_rise (write_rise)
   );

   // Held low during reset so the sender never sees a stale "ready".
   assign status_out = rst && (state_q == COLLECT) && !queue_full;

   // Next-state logic: shift on accepted edges, hand off a full word, wait for ack.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      enq_d   = enq_q;
      unique case (state_q)
         COLLECT: begin
            if (write_rise && status_out) begin
               shreg_d = {shreg_q[WIDTH-2:0], bit_sync};
               if (cnt_q == LAST_BIT) begin
                  data_d  = {shreg_q[WIDTH-2:0], bit_sync};
                  enq_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT_ACK;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WAIT_ACK: begin
            if (enq_ack) begin
               enq_d   = 1'b0;
               shreg_d = '0;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock_1MHz) begin
      if (!rst) begin
         state_q <= COLLECT;
         shreg_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         enq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         enq_q   <= enq_d;
      end
   end

   assign enq_out   = enq_q;
   assign data_out  = data_q;
   assign bit_count = cnt_q;

endmodule
